contador_param: RTL
===================

CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 Parameter NBITS_COUNT, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX_COUNT, default 2**NBITS_COUNT-1: terminal value (modulo MAX_COUNT+1), legal range 1..2**NBITS_COUNT-1.
REQ-003 Parameter PRESCALE, default 4: enabled clock cycles per count step when the prescaler is compiled in, legal range >=1.
REQ-004 clk  input  1  single clock, all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  count enable; when low, Count and the prescaler hold.
REQ-007 count_up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_value  input  NBITS_COUNT  value written on load.
REQ-010 sat_mode  input  1  boundary mode: 0 = wrap, 1 = saturate.
REQ-011 clear_ovf  input  1  synchronous clear of ovf.
REQ-012 Count  output  NBITS_COUNT  current count, registered.
REQ-013 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-014 ovf  output  1  sticky boundary flag, registered.

Function
REQ-015 Priority per posedge: load > count step > hold.
REQ-016 Load: Count <= min(load_value, MAX_COUNT); prescaler phase <= 0; tc <= 0; ovf unchanged.
REQ-017 Step: taken on a posedge where load=0, enable=1 and tick=1. tick is permanently 1 when the prescaler is compiled out.
REQ-018 Up step, Count<MAX_COUNT: Count <= Count+1.
REQ-019 Up step, Count==MAX_COUNT: Count <= 0 if sat_mode=0, else Count holds at MAX_COUNT.
REQ-020 Down step, Count>0: Count <= Count-1.
REQ-021 Down step, Count==0: Count <= MAX_COUNT if sat_mode=0, else Count holds at 0.
REQ-022 A step taken at a boundary (REQ-019/REQ-021) in either mode: tc=1 on the following cycle only and ovf <= 1.
REQ-023 tc=0 on every other cycle; consecutive boundary steps produce tc high on consecutive cycles.
REQ-024 clear_ovf clears ovf; if a boundary step occurs in the same cycle, the set wins (ovf=1).
REQ-025 count_up and sat_mode are sampled only at step edges; changing them between steps has no other effect.
REQ-026 Count is never outside 0..MAX_COUNT after reset, including after a load of an out-of-range value.

Reset
REQ-027 While reset=1, asynchronously and independent of clk: Count=0, tc=0, ovf=0, prescaler phase=0.
REQ-028 Reset asserted mid-prescale or mid-pulse aborts the pending tick/tc; the first step after release requires a full PRESCALE enabled cycles.

Configuration
REQ-029 Macro CONTADOR_PRESCALE_EN compiled in: a prescaler counts enabled cycles 0..PRESCALE-1; tick=1 only in the cycle where phase==PRESCALE-1 and enable=1; phase then returns to 0; phase holds while enable=0; load or reset sets phase to 0.
REQ-030 Macro CONTADOR_PRESCALE_EN absent: no prescaler logic; PRESCALE is ignored; a step occurs on every enabled, non-load cycle.

Structure
REQ-031 The shared package contador_pkg holds NBITS_COUNT/MAX_COUNT/PRESCALE default constants and the typedef count_dir_t (DIR_DOWN=0, DIR_UP=1).
REQ-032 One sub-module, contador_prescaler (parameter PRESCALE; ports clk, reset, enable, clear, tick), is instantiated only under CONTADOR_PRESCALE_EN.

Verification
REQ-033 NBITS_COUNT=4, MAX_COUNT=9, no prescaler, sat_mode=0, count_up=1, enable=1 from reset: Count steps 0..9, then 0; tc=1 exactly one cycle after the 9->0 edge; ovf=1 thereafter.
REQ-034 Same config, sat_mode=1, count_up=0 from reset: Count stays at 0; tc=1 every cycle; clear_ovf held high leaves ovf=1 (set wins).
REQ-035 load=1, load_value=13 with MAX_COUNT=9: Count=9 next cycle; load concurrent with enable=1 at Count=9 up yields Count=9 and tc=0.
REQ-036 CONTADOR_PRESCALE_EN, PRESCALE=4, enable=1, count_up=1: Count increments once per 4 cycles; enable dropped for 3 cycles mid-phase delays the next step by exactly 3 cycles.
REQ-037 reset pulsed asynchronously (between clock edges) at Count=5 with tc pending: Count=0, tc=0, ovf=0 immediately; counting resumes from 0 after release.
REQ-038 Wrap down: MAX_COUNT=9, sat_mode=0, count_up=0 from Count=1: Count steps to 0, then 9, with a tc pulse after the 0->9 edge.

Source files
------------

// File: rtl/contador_pkg.sv
// +-----------------------------------------------------------------------------
// | Module   : contador_pkg
// | Brief    : Shared default constants and direction type for contador_param.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package contador_pkg;

  localparam int unsigned c_DEF_NBITS_COUNT = 8;
  localparam int unsigned c_DEF_MAX_COUNT   = (1 << c_DEF_NBITS_COUNT) - 1;
  localparam int unsigned c_DEF_PRESCALE    = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_t;

endpackage

`default_nettype wire

// File: rtl/contador_prescaler.sv
// +-----------------------------------------------------------------------------
// | Module   : contador_prescaler
// | Brief    : Counts enabled cycles 0..PRESCALE-1 and flags the last one as tick.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module contador_prescaler
  import contador_pkg::*;
#(
  parameter int unsigned PRESCALE = c_DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0] c_LAST = c_PW'(PRESCALE - 1);

  logic [c_PW-1:0] phase_q;
  logic [c_PW-1:0] phase_d;

  assign tick = enable && (phase_q == c_LAST);

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (enable) begin
      phase_d = (phase_q == c_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/contador_param.sv
// +-----------------------------------------------------------------------------
// | Module   : contador_param
// | Brief    : Up/down modulo counter with load, wrap/saturate, tc pulse, sticky ovf.
// |            Optional prescaler enabled by macro CONTADOR_PRESCALE_EN.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module contador_param
  import contador_pkg::*;
#(
  parameter int unsigned             NBITS_COUNT = c_DEF_NBITS_COUNT,
  parameter logic [NBITS_COUNT-1:0]  MAX_COUNT   = {NBITS_COUNT{1'b1}},
  parameter int unsigned             PRESCALE    = c_DEF_PRESCALE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   count_up,
  input  logic                   load,
  input  logic [NBITS_COUNT-1:0] load_value,
  input  logic                   sat_mode,
  input  logic                   clear_ovf,
  output logic [NBITS_COUNT-1:0] Count,
  output logic                   tc,
  output logic                   ovf
);

  logic [NBITS_COUNT-1:0] count_q, count_d;
  logic                   tc_q, tc_d;
  logic                   ovf_q, ovf_d;
  logic                   w_tick;
  count_dir_t             w_dir;
  logic                   w_step;
  logic                   w_at_bound;

`ifdef CONTADOR_PRESCALE_EN
  contador_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable && !load),
    .clear  (load),
    .tick   (w_tick)
  );
`else
  // PRESCALE of zero is illegal, so this is a constant 1: every enabled cycle steps.
  assign w_tick = (PRESCALE != 0);
`endif

  assign w_dir      = count_dir_t'(count_up);
  assign w_step     = !load && enable && w_tick;
  assign w_at_bound = (w_dir == DIR_UP) ? (count_q == MAX_COUNT) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q && !clear_ovf;
    if (load) begin
      count_d = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
    end else if (w_step) begin
      if (w_at_bound) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (!sat_mode) begin
          count_d = (w_dir == DIR_UP) ? '0 : MAX_COUNT;
        end
      end else begin
        count_d = (w_dir == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

`default_nettype wire
